gen_frame_collector: RTL and testbench

GEN_FRAME_COLLECTOR -- requirements
Module: gen_frame_collector

---
 rtl/gen_pkg.sv | 16 +
 rtl/frame_ram.sv | 39 +++
 rtl/gen_frame_collector.sv | 148 ++++++++++++++
 tb/tb_gen_frame_collector.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared definitions for the generator frame collector: FSM states and default geometry.
package gen_pkg;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_READOUT = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 8;
  localparam int unsigned DEF_PIX_W      = 8;
  localparam int unsigned DEF_IMG_W      = 28;
  localparam int unsigned DEF_IMG_H      = 28;
  localparam int unsigned NPIX           = DEF_IMG_W * DEF_IMG_H;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port.
// Ports: clk, rst (clears the read register only), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (holds its value while rd_en is low).
module frame_ram
  import gen_pkg::*;
#(
  parameter int unsigned DEPTH = NPIX,
  parameter int unsigned WIDTH = DEF_PIX_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: no reset, contents are always rewritten before read-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the downstream output register, so it holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/gen_frame_collector.sv
// Collects one frame of signed fixed-point generator samples, quantises them to
// unsigned pixels, stores them, then streams the frame out with valid/ready.
// Ports: clk, rst (sync, active-high); valid_in/data_in sample input;
//        in_ready (FILL), frame_done pulse, overrun sticky flag;
//        out_valid/out_ready/out_data/out_last read-out stream.
module gen_frame_collector
  import gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         in_ready,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIX_W-1:0]             out_data,
  output logic                         out_last
);

  localparam int unsigned NPX  = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPX);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TW   = DATA_WIDTH + 1;
  localparam int unsigned SH   = FRAC_BITS + 1 - PIX_W;
  localparam int unsigned PMAX = (2 ** PIX_W) - 1;
  localparam logic signed [TW-1:0] BIAS = TW'(2 ** FRAC_BITS);

  state_t state_q, state_d;

  logic [AW-1:0]    wr_cnt;
  logic [CW-1:0]    rd_cnt;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [PIX_W-1:0] wr_data_q;

  logic signed [TW-1:0] t_c;
  logic [TW-1:0]        sh_c;
  logic [PIX_W-1:0]     q_c;
  logic                 accept_c;
  logic                 last_wr_c;
  logic                 rd_issue_c;
  logic                 last_xfer_c;

  // Quantiser: bias to unsigned range, floor negatives, scale, saturate.
  always_comb begin
    t_c  = TW'(data_in) + BIAS;
    sh_c = '0;
    q_c  = '0;
    if (!t_c[TW-1]) begin
      sh_c = unsigned'(t_c) >> SH;
    end
    if (sh_c > TW'(PMAX)) begin
      q_c = PIX_W'(PMAX);
    end else begin
      q_c = sh_c[PIX_W-1:0];
    end
  end

  // Handshake decodes; a read is issued whenever the output register is free or draining.
  always_comb begin
    accept_c    = valid_in && (state_q == ST_FILL);
    last_wr_c   = accept_c && (wr_cnt == AW'(NPX - 1));
    rd_issue_c  = (state_q == ST_READOUT) && (!out_valid || out_ready) && (rd_cnt < CW'(NPX));
    last_xfer_c = out_valid && out_ready && out_last;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:    if (last_wr_c)   state_d = ST_READOUT;
      ST_READOUT: if (last_xfer_c) state_d = ST_FILL;
      default:    state_d = ST_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, write pipeline and registered status/stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      in_ready   <= (state_d == ST_FILL);
      frame_done <= last_wr_c;
      wr_en_q    <= accept_c;
      wr_addr_q  <= wr_cnt;
      wr_data_q  <= q_c;
      if (valid_in && !in_ready) begin
        overrun <= 1'b1;
      end
      if (accept_c) begin
        wr_cnt <= last_wr_c ? '0 : wr_cnt + AW'(1);
      end
      if (rd_issue_c) begin
        rd_cnt    <= rd_cnt + CW'(1);
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == CW'(NPX - 1));
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (last_xfer_c) begin
        rd_cnt <= '0;
      end
    end
  end

  frame_ram #(
    .DEPTH (NPX),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (rd_issue_c),
    .rd_addr (rd_cnt[AW-1:0]),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_gen_frame_collector.sv
// Randomised self-checking bench for gen_frame_collector with a behavioural frame model.
module tb_gen_frame_collector;

  localparam int NPIX     = 784;
  localparam int FRAC     = 8;
  localparam int PIXW     = 8;
  localparam int SPARSE_N = 48;
  localparam int BUDGET   = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic signed [15:0] data_in;
  logic        in_ready;
  logic        frame_done;
  logic        overrun;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int n_assert = 0;
  int n_fail   = 0;
  int stim   [NPIX];
  int exp_px [NPIX];
  int got    [$];
  int stable_err;
  int last_err;
  int notready;

  gen_frame_collector dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .frame_done (frame_done),
    .overrun    (overrun),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // Reference quantiser computed from the arithmetic rule on unbounded integers.
  function automatic int q_model(input int d);
    int t;
    t = d + (1 << FRAC);
    if (t < 0) return 0;
    t = t / (1 << (FRAC + 1 - PIXW));
    if (t > (1 << PIXW) - 1) return (1 << PIXW) - 1;
    return t;
  endfunction

  function automatic int first_mismatch();
    if (got.size() != NPIX) return got.size();
    for (int i = 0; i < NPIX; i++) if (got[i] != exp_px[i]) return i;
    return -1;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(0, 9) == 0) stim[i] = int'($signed(16'($urandom)));
      else stim[i] = int'($urandom_range(0, 1200)) - 400;
    end
  endtask

  task automatic build_expect();
    for (int i = 0; i < NPIX; i++) exp_px[i] = q_model(stim[i]);
  endtask

  // Drives n samples; sparse mode spaces the first SPARSE_N samples out widely.
  task automatic send_frame(input int n, input bit sparse);
    notready = 0;
    for (int i = 0; i < n; i++) begin
      if (sparse && i < SPARSE_N) begin
        int gap;
        gap = 299 + ((i > 0 && i % 8 == 0) ? 5000 : 0);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          if (!in_ready) notready++;
        end
      end
      valid_in = 1'b1;
      data_in  = 16'(stim[i]);
      if (!in_ready) notready++;
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  // Captures one frame of transfers with out_ready high pct percent of cycles.
  task automatic collect(input int pct);
    bit   r;
    bit   prev_stall;
    logic [7:0] prev_data;
    int   cyc;
    got.delete();
    stable_err = 0;
    last_err   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    cyc        = 0;
    while (got.size() < NPIX && cyc < BUDGET) begin
      r = ($urandom_range(0, 99) < pct);
      out_ready = r;
      if (out_valid) begin
        if (prev_stall && out_data !== prev_data) stable_err++;
        if (r) begin
          got.push_back(int'(out_data));
          if (out_last !== (got.size() == NPIX)) last_err++;
        end else if (out_last && got.size() != NPIX - 1) begin
          last_err++;
        end
        prev_stall = !r;
        prev_data  = out_data;
      end else begin
        if (prev_stall) stable_err++;
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({in_ready, out_valid, out_last, frame_done, overrun} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 10000", {in_ready, out_valid, out_last, frame_done, overrun});
    end
    n_assert++;
    if (out_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d expected 0", out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    int mm;
    for (int i = 0; i < NPIX; i++) stim[i] = -256 + (i % 513);
    build_expect();
    send_frame(NPIX, 1'b0);
    n_assert++;
    if (frame_done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_done_pulse: got done=%b ready=%b expected done=1 ready=0", frame_done, in_ready);
    end
    @(posedge clk); #1;
    n_assert++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_done_width: got %b expected 0", frame_done);
    end
    n_assert++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_first_valid: got %b expected 1", out_valid);
    end
    collect(100);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL ramp_frame: first bad index %0d of %0d pixels, expected all %0d to match", mm, got.size(), NPIX);
    end
    n_assert++;
    if (last_err != 0) begin
      n_fail++;
      $display("FAIL ramp_last: got %0d misplaced out_last expected 0", last_err);
    end
    n_assert++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_return_fill: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_clamp();
    int cl_in  [6] = '{-300, -256, 0, 255, 256, 1000};
    int cl_exp [6] = '{0, 0, 128, 255, 255, 255};
    fill_random();
    for (int k = 0; k < 6; k++) stim[k] = cl_in[k];
    send_frame(NPIX, 1'b0);
    collect(100);
    for (int k = 0; k < 6; k++) begin
      n_assert++;
      if (got.size() <= k || got[k] != cl_exp[k]) begin
        n_fail++;
        $display("FAIL clamp_px%0d: got %0d expected %0d", k, (got.size() > k) ? got[k] : -1, cl_exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int mm;
    fill_random();
    build_expect();
    send_frame(NPIX, 1'b0);
    collect(50);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL bp_frame: first bad index %0d of %0d pixels, expected %0d matching", mm, got.size(), NPIX);
    end
    n_assert++;
    if (stable_err != 0 || last_err != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable %0d misplaced last, expected 0 0", stable_err, last_err);
    end
    @(posedge clk); #1;
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_extra_transfer: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_overrun();
    int mm;
    fill_random();
    build_expect();
    send_frame(NPIX, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      data_in  = 16'(1000 - 300 * k);
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(posedge clk); #1;
    end
    n_assert++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b expected 1", overrun);
    end
    collect(100);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL ovr_frame: first bad index %0d of %0d pixels, expected %0d matching", mm, got.size(), NPIX);
    end
    fill_random();
    build_expect();
    send_frame(NPIX, 1'b0);
    collect(100);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL ovr_next_frame: first bad index %0d of %0d pixels, expected %0d matching", mm, got.size(), NPIX);
    end
    n_assert++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int mm;
    fill_random();
    send_frame(400, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_assert++;
    if (in_ready !== 1'b1 || overrun !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got ready=%b ovr=%b valid=%b expected 1 0 0", in_ready, overrun, out_valid);
    end
    fill_random();
    build_expect();
    send_frame(NPIX, 1'b0);
    collect(100);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL rst_mid_frame: first bad index %0d of %0d pixels, expected %0d matching", mm, got.size(), NPIX);
    end
    n_assert++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_sparse();
    int mm;
    for (int i = 0; i < NPIX; i++) stim[i] = -256 + (i % 513);
    build_expect();
    send_frame(NPIX, 1'b1);
    n_assert++;
    if (notready != 0) begin
      n_fail++;
      $display("FAIL sparse_in_ready: got %0d low cycles expected 0", notready);
    end
    collect(100);
    mm = first_mismatch();
    n_assert++;
    if (mm >= 0) begin
      n_fail++;
      $display("FAIL sparse_frame: first bad index %0d of %0d pixels, expected %0d matching", mm, got.size(), NPIX);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_backpressure();
    test_overrun();
    test_reset_mid_frame();
    test_sparse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
